stopwatch_timer: RTL and testbench

//  Parametrised BCD stopwatch/countdown timer: M:SS.t display digits, internal tenth-second prescaler,

---
 rtl/stopwatch_timer_pkg.sv | 18 +
 rtl/stopwatch_timer_if.sv | 40 ++++
 rtl/stopwatch_timer_bcd_digit_counter.sv | 47 ++++
 rtl/stopwatch_timer.sv | 148 ++++++++++++++
 tb/tb_stopwatch_timer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_timer_pkg.sv
// Shared constants for the BCD stopwatch/countdown timer: state encoding and digit limits.
package stopwatch_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] TENS_MAX  = 4'd5;

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StRun     = 2'd1;
  localparam logic [1:0] StPaused  = 2'd2;
  localparam logic [1:0] StExpired = 2'd3;

  function automatic logic [DIGIT_W-1:0] bcd_clamp(input logic [DIGIT_W-1:0] d,
                                                   input logic [DIGIT_W-1:0] max);
    return (d > max) ? max : d;
  endfunction

endpackage

// File: rtl/stopwatch_timer_if.sv
// Button-pulse / display-digit bundle for stopwatch_timer.
// STOPWATCH_LAP_EN adds the lap capture pulse and lap_time digits.
interface stopwatch_timer_if #(
  parameter int unsigned MIN_DIGITS = 1
);
  logic                      start;
  logic                      stop;
  logic                      clear;
  logic                      countdown;
  logic                      load;
  logic [4*MIN_DIGITS+11:0]  load_val;
  logic [4*MIN_DIGITS-1:0]   minutes;
  logic [3:0]                tens_seconds;
  logic [3:0]                ones_seconds;
  logic [3:0]                tenths_seconds;
  logic                      running;
  logic                      done;
`ifdef STOPWATCH_LAP_EN
  logic                      lap;
  logic [4*MIN_DIGITS+11:0]  lap_time;

  modport master (
    output start, stop, clear, countdown, load, load_val, lap,
    input  minutes, tens_seconds, ones_seconds, tenths_seconds, running, done, lap_time
  );
  modport slave (
    input  start, stop, clear, countdown, load, load_val, lap,
    output minutes, tens_seconds, ones_seconds, tenths_seconds, running, done, lap_time
  );
`else
  modport master (
    output start, stop, clear, countdown, load, load_val,
    input  minutes, tens_seconds, ones_seconds, tenths_seconds, running, done
  );
  modport slave (
    input  start, stop, clear, countdown, load, load_val,
    output minutes, tens_seconds, ones_seconds, tenths_seconds, running, done
  );
`endif
endinterface

// File: rtl/stopwatch_timer_bcd_digit_counter.sv
// One BCD digit (0..MAX) with increment/decrement, clamped preset and combinational carry/borrow.
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter logic [DIGIT_W-1:0] MAX = DIGIT_MAX
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic               load_i,
  input  logic [DIGIT_W-1:0] load_val_i,
  input  logic               inc_i,
  input  logic               dec_i,
  output logic [DIGIT_W-1:0] q_o,
  output logic               carry_o,
  output logic               borrow_o
);

  logic [DIGIT_W-1:0] q_d, q_q;

  assign carry_o  = inc_i & (q_q == MAX);
  assign borrow_o = dec_i & (q_q == '0);

  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (load_i) begin
      q_d = bcd_clamp(load_val_i, MAX);
    end else if (inc_i) begin
      q_d = carry_o ? '0 : q_q + 4'd1;
    end else if (dec_i) begin
      q_d = borrow_o ? MAX : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/stopwatch_timer.sv
// BCD M:SS.t stopwatch / countdown timer with tenth-second prescaler and run/pause/expired FSM.
// Define STOPWATCH_LAP_EN to build the lap capture register.
module stopwatch_timer
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 10_000_000,
  parameter int unsigned MIN_DIGITS = 1
) (
  input logic           clk,
  input logic           reset_n,
  stopwatch_timer_if.slave sw
);

  // Digit 0 is tenths, 1 ones, 2 tens of seconds, 3.. minutes (LSD first).
  localparam int unsigned NumDig = MIN_DIGITS + 3;
  localparam int unsigned PresW  = $clog2(TICK_DIV);
  localparam logic [PresW-1:0] PresMax = PresW'(TICK_DIV - 1);

  logic [1:0]       state_d, state_q;
  logic             mode_d, mode_q;
  logic [PresW-1:0] presc_d, presc_q;
  logic             done_d, done_q;
  logic             running_d, running_q;

  logic [NumDig-1:0][DIGIT_W-1:0] digit;
  logic [NumDig-1:0]              carry, borrow;
  logic tick_up, tick_dn, load_ok, value_zero, one_left;

  assign value_zero = (digit == '0);
  assign one_left   = (digit[0] == 4'd1) && (digit[NumDig-1:1] == '0);
  assign load_ok    = sw.load && (state_q != StRun);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    tick_up = 1'b0;
    tick_dn = 1'b0;
    if (sw.clear) begin
      state_d = StIdle;
      presc_d = '0;
    end else if (load_ok) begin
      presc_d = '0;
      if (state_q == StExpired) state_d = StPaused;
    end else if (sw.stop) begin
      if (state_q == StRun) state_d = StPaused;
    end else if (state_q == StRun) begin
      if (presc_q == PresMax) begin
        presc_d = '0;
        if (!mode_q) begin
          tick_up = 1'b1;
        end else begin
          // Down mode never wraps: the tick that lands on zero expires the timer.
          tick_dn = !value_zero;
          if (value_zero || one_left) begin
            done_d  = 1'b1;
            state_d = StExpired;
          end
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end else if (sw.start) begin
      if (state_q == StIdle && !(sw.countdown && value_zero)) begin
        mode_d  = sw.countdown;
        presc_d = '0;
        state_d = StRun;
      end else if (state_q == StPaused) begin
        state_d = StRun;
      end
    end
    running_d = (state_d == StRun);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      mode_q    <= 1'b0;
      presc_q   <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      presc_q   <= presc_d;
      done_q    <= done_d;
      running_q <= running_d;
    end
  end

  for (genvar i = 0; i < NumDig; i++) begin : g_digit
    logic inc, dec;
    if (i == 0) begin : g_lsd
      assign inc = tick_up;
      assign dec = tick_dn;
    end else begin : g_chain
      assign inc = carry[i-1];
      assign dec = borrow[i-1];
    end
    bcd_digit_counter #(
      .MAX ((i == 2) ? TENS_MAX : DIGIT_MAX)
    ) u_digit (
      .clk_i      (clk),
      .rst_ni     (reset_n),
      .clr_i      (sw.clear),
      .load_i     (load_ok),
      .load_val_i (sw.load_val[4*i +: 4]),
      .inc_i      (inc),
      .dec_i      (dec),
      .q_o        (digit[i]),
      .carry_o    (carry[i]),
      .borrow_o   (borrow[i])
    );
  end

  // Carry/borrow out of the top minute digit is the wrap indication, deliberately dropped.
  logic unused_top;
  assign unused_top = carry[NumDig-1] ^ borrow[NumDig-1];

`ifdef STOPWATCH_LAP_EN
  logic [4*NumDig-1:0] lap_d, lap_q;

  always_comb begin
    lap_d = lap_q;
    if (sw.clear)    lap_d = '0;
    else if (sw.lap) lap_d = digit;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lap_q <= '0;
    end else begin
      lap_q <= lap_d;
    end
  end

  assign sw.lap_time = lap_q;
`endif

  assign sw.tenths_seconds = digit[0];
  assign sw.ones_seconds   = digit[1];
  assign sw.tens_seconds   = digit[2];
  assign sw.minutes        = digit[NumDig-1:3];
  assign sw.running        = running_q;
  assign sw.done           = done_q;

endmodule

// File: tb/tb_stopwatch_timer.sv
// Scoreboard bench for stopwatch_timer (TICK_DIV=4, MIN_DIGITS=1) with an integer-tenths model.
module tb_stopwatch_timer;

  localparam int TickDiv = 4;
  localparam int MaxT    = 6000;
  localparam int MIdle = 0, MRun = 1, MPaused = 2, MExpired = 3;

  typedef struct {
    logic [15:0] digits;
    logic        running;
    logic        done;
    logic [15:0] lap;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  int m_t = 0, m_st = MIdle, m_presc = 0, m_lap = 0;
  bit m_mode = 0, m_done = 0;

  stopwatch_timer_if #(.MIN_DIGITS(1)) sw ();

  stopwatch_timer #(
    .TICK_DIV   (TickDiv),
    .MIN_DIGITS (1)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sw      (sw)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int t);
    int s;
    s = (t % 600) / 10;
    return {4'(t / 600), 4'(s / 10), 4'(s % 10), 4'(t % 10)};
  endfunction

  function automatic int clampn(input logic [3:0] d, input int mx);
    return (int'(d) > mx) ? mx : int'(d);
  endfunction

  function automatic int load_to_t(input logic [15:0] v);
    return clampn(v[15:12], 9) * 600 + clampn(v[11:8], 5) * 100 +
           clampn(v[7:4], 9) * 10 + clampn(v[3:0], 9);
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic logic [15:0] disp();
    return {sw.minutes, sw.tens_seconds, sw.ones_seconds, sw.tenths_seconds};
  endfunction

  task automatic model_step();
    m_done = 0;
    if (!reset_n) begin
      m_t = 0; m_st = MIdle; m_presc = 0; m_mode = 0; m_lap = 0;
      return;
    end
    if (sw.clear) begin
      m_t = 0; m_st = MIdle; m_presc = 0; m_lap = 0;
      return;
    end
`ifdef STOPWATCH_LAP_EN
    if (sw.lap) m_lap = m_t;
`endif
    if (sw.load && m_st != MRun) begin
      m_t = load_to_t(sw.load_val);
      m_presc = 0;
      if (m_st == MExpired) m_st = MPaused;
    end else if (sw.stop) begin
      if (m_st == MRun) m_st = MPaused;
    end else if (m_st == MRun) begin
      m_presc++;
      if (m_presc == TickDiv) begin
        m_presc = 0;
        if (!m_mode) m_t = (m_t + 1) % MaxT;
        else if (m_t <= 1) begin
          m_t = 0; m_done = 1; m_st = MExpired;
        end else m_t--;
      end
    end else if (sw.start) begin
      if (m_st == MIdle && !(sw.countdown && m_t == 0)) begin
        m_mode = sw.countdown; m_presc = 0; m_st = MRun;
      end else if (m_st == MPaused) m_st = MRun;
    end
  endtask

  // Reference model: advances on every active edge and queues the expected outputs.
  initial forever begin
    exp_t e;
    @(posedge clk);
    model_step();
    e.digits  = to_bcd(m_t);
    e.running = (m_st == MRun);
    e.done    = m_done;
    e.lap     = to_bcd(m_lap);
    sb.push_back(e);
  end

  // Monitor: compares DUT outputs against the queued expectation half a cycle later.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sb_digits", disp(), e.digits);
      chk("sb_running", {15'b0, sw.running}, {15'b0, e.running});
      chk("sb_done", {15'b0, sw.done}, {15'b0, e.done});
`ifdef STOPWATCH_LAP_EN
      chk("sb_lap", sw.lap_time, e.lap);
`endif
    end
  end

  task automatic zero_pulses();
    sw.start = 0; sw.stop = 0; sw.clear = 0; sw.load = 0;
`ifdef STOPWATCH_LAP_EN
    sw.lap = 0;
`endif
  endtask

  task automatic cyc(input int n);
    @(negedge clk);
    zero_pulses();
    repeat (n - 1) @(negedge clk);
  endtask

  initial begin
    zero_pulses();
    sw.countdown = 0;
    sw.load_val  = '0;
    repeat (3) @(negedge clk);
    chk("reset_digits", disp(), 16'h0000);
    chk("reset_running", {15'b0, sw.running}, 16'h0);
    chk("reset_done", {15'b0, sw.done}, 16'h0);
    reset_n = 1;

    // Count up, pause, resume
    sw.start = 1; cyc(1); cyc(40);
    chk("up_1s", disp(), 16'h0010);
    chk("up_running", {15'b0, sw.running}, 16'h1);
    sw.stop = 1; cyc(1); cyc(20);
    chk("pause_frozen", disp(), 16'h0010);
    chk("pause_running", {15'b0, sw.running}, 16'h0);
    sw.start = 1; cyc(1); cyc(4);
    chk("resume", disp(), 16'h0011);

    // Wrap at maximum
    sw.clear = 1; cyc(1);
    chk("clear_run", disp(), 16'h0000);
    sw.load = 1; sw.load_val = 16'h9598; cyc(1);
    chk("load_idle", disp(), 16'h9598);
    sw.start = 1; cyc(1); cyc(8);
    chk("wrap_digits", disp(), 16'h0000);
    chk("wrap_done", {15'b0, sw.done}, 16'h0);
    chk("wrap_running", {15'b0, sw.running}, 16'h1);

    // Countdown to expiry
    sw.clear = 1; cyc(1);
    sw.load = 1; sw.load_val = 16'h0002; cyc(1);
    sw.countdown = 1; sw.start = 1; cyc(1); sw.countdown = 0;
    cyc(4);
    chk("down_1", disp(), 16'h0001);
    cyc(4);
    chk("down_0", disp(), 16'h0000);
    chk("down_done", {15'b0, sw.done}, 16'h1);
    chk("expired_running", {15'b0, sw.running}, 16'h0);
    cyc(1);
    chk("done_pulse", {15'b0, sw.done}, 16'h0);
    sw.start = 1; cyc(1); cyc(4);
    chk("expired_ignores_start", {15'b0, sw.running}, 16'h0);
    sw.load = 1; sw.load_val = 16'h0005; cyc(1);
    chk("load_expired", disp(), 16'h0005);
    sw.start = 1; cyc(1);
    chk("paused_start", {15'b0, sw.running}, 16'h1);
    cyc(4);
    chk("down_after_load", disp(), 16'h0004);

    // Priority
    sw.clear = 1; sw.start = 1; cyc(1);
    chk("clear_beats_start", disp(), 16'h0000);
    chk("clear_beats_start_run", {15'b0, sw.running}, 16'h0);
    sw.start = 1; cyc(1);
    sw.stop = 1; cyc(1);
    sw.start = 1; sw.stop = 1; cyc(1);
    chk("stop_beats_start", {15'b0, sw.running}, 16'h0);

    // Clamp, load ignored in RUN, async reset
    sw.clear = 1; cyc(1);
    sw.load = 1; sw.load_val = 16'hF7FA; cyc(1);
    chk("load_clamp", disp(), 16'h9599);
    sw.start = 1; cyc(1);
    sw.load = 1; sw.load_val = 16'h1234; cyc(1);
    chk("load_in_run", disp(), 16'h9599);
    cyc(2);
    #2 reset_n = 0;
    #1;
    chk("async_reset_digits", disp(), 16'h0000);
    chk("async_reset_running", {15'b0, sw.running}, 16'h0);
    @(negedge clk);
    reset_n = 1;
    cyc(1);

`ifdef STOPWATCH_LAP_EN
    sw.start = 1; cyc(1); cyc(92);
    chk("lap_pre", disp(), 16'h0023);
    sw.lap = 1; cyc(1);
    chk("lap_capture", sw.lap_time, 16'h0023);
    cyc(4);
    chk("lap_keeps_counting", disp(), 16'h0024);
    chk("lap_held", sw.lap_time, 16'h0023);
    sw.clear = 1; cyc(1);
    chk("lap_clear", sw.lap_time, 16'h0000);
`endif

    // Randomized traffic checked only by the scoreboard
    for (int i = 0; i < 3000; i++) begin
      sw.start     = ($urandom_range(0, 99) < 10);
      sw.stop      = ($urandom_range(0, 99) < 5);
      sw.clear     = ($urandom_range(0, 99) < 2);
      sw.load      = ($urandom_range(0, 99) < 4);
      sw.countdown = $urandom_range(0, 1);
`ifdef STOPWATCH_LAP_EN
      sw.lap       = ($urandom_range(0, 99) < 5);
`endif
      if ($urandom_range(0, 1) == 1) sw.load_val = 16'($urandom);
      else sw.load_val = to_bcd($urandom_range(0, 40));
      @(negedge clk);
    end
    zero_pulses();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
